// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - next-PC redirect handshake between the branch unit and fetch
//
// Purpose: carries one redirect request from the branch unit to fetch.
// Signals:
//   jump_valid   branch unit -> fetch   redirect request pending
//   jump_target  branch unit -> fetch   next PC
//   jump_taken   branch unit -> fetch   1 = taken branch or JALR
//   jump_ack     fetch -> branch unit   fetch accepts the request this cycle
// Modports: master = branch unit side, slave = fetch side.

interface branch_unit_if #(
    parameter int XLEN = 32
);
    logic            jump_valid;
    logic [XLEN-1:0] jump_target;
    logic            jump_taken;
    logic            jump_ack;

    modport master (
        output jump_valid,
        output jump_target,
        output jump_taken,
        input  jump_ack
    );

    modport slave (
        input  jump_valid,
        input  jump_target,
        input  jump_taken,
        output jump_ack
    );
endinterface

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch/JALR resolution at the execution end of the branch reservation station
//
// Purpose: captures the station's held entry, waits for its operands to unlock,
// resolves the branch or JALR and hands the next PC to fetch over a
// valid/ack handshake. A redirect is issued for every entry, taken or not.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   rdy             global ready; 0 freezes all state and outputs
//   pc_in           entry PC
//   offset_in       sign-extended immediate
//   busy_in         station entry valid
//   op_in           branch op code
//   tagx_in/tagy_in operand tags (UNLOCKED = data valid)
//   datax_in/datay_in operand values, re-read live while waiting
//   busy_branch     1 = station must keep the entry
//   jmp             redirect handshake to fetch (master side)

module branch_unit #(
    parameter int            OP_W     = 6,
    parameter int            TAG_W    = 4,
    parameter int            XLEN     = 32,
    parameter logic [TAG_W-1:0] UNLOCKED = '0,
    parameter logic [OP_W-1:0]  OP_BEQ   = 6'd1,
    parameter logic [OP_W-1:0]  OP_BNE   = 6'd2,
    parameter logic [OP_W-1:0]  OP_BLT   = 6'd3,
    parameter logic [OP_W-1:0]  OP_BGE   = 6'd4,
    parameter logic [OP_W-1:0]  OP_BLTU  = 6'd5,
    parameter logic [OP_W-1:0]  OP_BGEU  = 6'd6,
    parameter logic [OP_W-1:0]  OP_JALR  = 6'd7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  offset_in,
    input  logic             busy_in,
    input  logic [OP_W-1:0]  op_in,
    input  logic [TAG_W-1:0] tagx_in,
    input  logic [TAG_W-1:0] tagy_in,
    input  logic [XLEN-1:0]  datax_in,
    input  logic [XLEN-1:0]  datay_in,
    output logic             busy_branch,
    branch_unit_if.master    jmp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2,
        ST_REQ  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_off;
    logic [OP_W-1:0] r_op;
    logic [XLEN-1:0] r_x;
    logic [XLEN-1:0] r_y;

    logic            w_operands_ready;
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_seq_target;
    logic [XLEN-1:0] w_jalr_sum;

    // JALR has no rs2, so its tagy is meaningless and must not stall it.
    assign w_operands_ready = (tagx_in == UNLOCKED) &&
                              ((r_op == OP_JALR) || (tagy_in == UNLOCKED));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (busy_in)          w_next_state = ST_WAIT;
            ST_WAIT: if (w_operands_ready) w_next_state = ST_EXEC;
            ST_EXEC:                       w_next_state = ST_REQ;
            ST_REQ:  if (jmp.jump_ack)     w_next_state = ST_IDLE;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    // Resolution logic, evaluated from the latched entry during EXEC
    assign w_br_target  = r_pc + r_off;
    assign w_seq_target = r_pc + XLEN'(4);
    assign w_jalr_sum   = r_x + r_off;

    always_comb begin
        w_taken  = 1'b0;
        w_target = w_seq_target;
        case (r_op)
            OP_BEQ:  w_taken = (r_x == r_y);
            OP_BNE:  w_taken = (r_x != r_y);
            OP_BLT:  w_taken = ($signed(r_x) <  $signed(r_y));
            OP_BGE:  w_taken = ($signed(r_x) >= $signed(r_y));
            OP_BLTU: w_taken = (r_x <  r_y);
            OP_BGEU: w_taken = (r_x >= r_y);
            default: w_taken = 1'b0;
        endcase
        if (r_op == OP_JALR) begin
            w_taken  = 1'b1;
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        end else if (w_taken) begin
            w_target = w_br_target;
        end
    end

    // Entry latches and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= '0;
            r_off           <= '0;
            r_op            <= '0;
            r_x             <= '0;
            r_y             <= '0;
            busy_branch     <= 1'b0;
            jmp.jump_valid  <= 1'b0;
            jmp.jump_target <= '0;
            jmp.jump_taken  <= 1'b0;
        end else if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (busy_in) begin
                        r_pc        <= pc_in;
                        r_off       <= offset_in;
                        r_op        <= op_in;
                        busy_branch <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Operand data is only trusted on the cycle its tags unlock.
                    if (w_operands_ready) begin
                        r_x <= datax_in;
                        r_y <= datay_in;
                    end
                end
                ST_EXEC: begin
                    jmp.jump_target <= w_target;
                    jmp.jump_taken  <= w_taken;
                    jmp.jump_valid  <= 1'b1;
                end
                ST_REQ: begin
                    // busy_branch drops on the same edge as the ack so the
                    // station frees the entry only once fetch has the redirect.
                    if (jmp.jump_ack) begin
                        jmp.jump_valid <= 1'b0;
                        busy_branch    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed self-checking bench for branch_unit

module tb_branch_unit;

    localparam logic [5:0] BEQ  = 6'd1;
    localparam logic [5:0] BNE  = 6'd2;
    localparam logic [5:0] BLT  = 6'd3;
    localparam logic [5:0] BGE  = 6'd4;
    localparam logic [5:0] BLTU = 6'd5;
    localparam logic [5:0] BGEU = 6'd6;
    localparam logic [5:0] JALR = 6'd7;
    localparam logic [5:0] BAD  = 6'h3F;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] pc_in;
    logic [31:0] offset_in;
    logic        busy_in;
    logic [5:0]  op_in;
    logic [3:0]  tagx_in;
    logic [3:0]  tagy_in;
    logic [31:0] datax_in;
    logic [31:0] datay_in;
    logic        busy_branch;

    int checks;
    int errors;

    branch_unit_if #(.XLEN(32)) jmp_if ();

    branch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .pc_in       (pc_in),
        .offset_in   (offset_in),
        .busy_in     (busy_in),
        .op_in       (op_in),
        .tagx_in     (tagx_in),
        .tagy_in     (tagy_in),
        .datax_in    (datax_in),
        .datay_in    (datay_in),
        .busy_branch (busy_branch),
        .jmp         (jmp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] off,
                           input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] tx, input logic [3:0] ty);
        busy_in   = 1'b1;
        op_in     = op;
        pc_in     = pc;
        offset_in = off;
        datax_in  = x;
        datay_in  = y;
        tagx_in   = tx;
        tagy_in   = ty;
    endtask

    // Cycles (after the capture edge) until jump_valid is seen; 20 means it never came.
    task automatic wait_valid(output int n);
        n = 0;
        while (jmp_if.jump_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Acknowledge the pending request and let the station free the entry.
    task automatic ack_and_free();
        jmp_if.jump_ack = 1'b1;
        tick();
        jmp_if.jump_ack = 1'b0;
        busy_in         = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; busy_in = 1'b0; jmp_if.jump_ack = 1'b0;
        op_in = '0; pc_in = '0; offset_in = '0; datax_in = '0; datay_in = '0;
        tagx_in = '0; tagy_in = '0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({busy_branch, jmp_if.jump_valid, jmp_if.jump_taken} !== 3'b000 || jmp_if.jump_target !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b taken=%b target=%h required all 0",
                     busy_branch, jmp_if.jump_valid, jmp_if.jump_taken, jmp_if.jump_target);
        end
    endtask

    task automatic test_beq_taken();
        int n;
        present(BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 4'd0, 4'd0);
        tick();
        checks++;
        if (busy_branch !== 1'b1) begin
            errors++; $display("FAIL beq_busy_capture: got %b required 1", busy_branch);
        end
        wait_valid(n);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL beq_latency: got %0d cycles required 2", n);
        end
        checks++;
        if (jmp_if.jump_target !== 32'h120 || jmp_if.jump_taken !== 1'b1) begin
            errors++; $display("FAIL beq_result: got target=%h taken=%b required 00000120/1",
                               jmp_if.jump_target, jmp_if.jump_taken);
        end
        ack_and_free();
        checks++;
        if (busy_branch !== 1'b0 || jmp_if.jump_valid !== 1'b0) begin
            errors++; $display("FAIL beq_ack_release: got busy=%b valid=%b required 0/0",
                               busy_branch, jmp_if.jump_valid);
        end
        tick();
        checks++;
        if (busy_branch !== 1'b0) begin
            errors++; $display("FAIL beq_idle_after_ack: got busy=%b required 0", busy_branch);
        end
    endtask

    task automatic test_signed_unsigned();
        int n;
        present(BLT, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0);
        tick(); wait_valid(n);
        checks++;
        if (n != 2 || jmp_if.jump_target !== 32'h240 || jmp_if.jump_taken !== 1'b1) begin
            errors++; $display("FAIL blt_signed: got n=%0d target=%h taken=%b required 2/00000240/1",
                               n, jmp_if.jump_target, jmp_if.jump_taken);
        end
        ack_and_free();
        present(BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0);
        tick(); wait_valid(n);
        checks++;
        if (n != 2 || jmp_if.jump_target !== 32'h204 || jmp_if.jump_taken !== 1'b0) begin
            errors++; $display("FAIL bltu_unsigned: got n=%0d target=%h taken=%b required 2/00000204/0",
                               n, jmp_if.jump_target, jmp_if.jump_taken);
        end
        ack_and_free();
        present(BGEU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0);
        tick(); wait_valid(n);
        checks++;
        if (jmp_if.jump_target !== 32'h240 || jmp_if.jump_taken !== 1'b1) begin
            errors++; $display("FAIL bgeu_unsigned: got target=%h taken=%b required 00000240/1",
                               jmp_if.jump_target, jmp_if.jump_taken);
        end
        ack_and_free();
        present(BAD, 32'h700, 32'h80, 32'd1, 32'd2, 4'd0, 4'd0);
        tick(); wait_valid(n);
        checks++;
        if (jmp_if.jump_target !== 32'h704 || jmp_if.jump_taken !== 1'b0) begin
            errors++; $display("FAIL unknown_op: got target=%h taken=%b required 00000704/0",
                               jmp_if.jump_target, jmp_if.jump_taken);
        end
        ack_and_free();
    endtask

    task automatic test_tag_stall();
        int n;
        // datay=7 equals datax while locked; only the unlocked value 8 makes BNE taken.
        present(BNE, 32'h300, 32'h10, 32'd7, 32'd7, 4'd0, 4'd3);
        tick();
        jmp_if.jump_ack = 1'b1;   // stray ack while no request is pending
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (jmp_if.jump_valid !== 1'b0 || busy_branch !== 1'b1) begin
                errors++; $display("FAIL bne_stall_cycle%0d: got valid=%b busy=%b required 0/1",
                                   i, jmp_if.jump_valid, busy_branch);
            end
        end
        jmp_if.jump_ack = 1'b0;
        datay_in = 32'd8;
        tagy_in  = 4'd0;
        wait_valid(n);
        checks++;
        if (n + 4 != 6) begin
            errors++; $display("FAIL bne_stall_latency: got %0d cycles required 6", n + 4);
        end
        checks++;
        if (jmp_if.jump_target !== 32'h310 || jmp_if.jump_taken !== 1'b1) begin
            errors++; $display("FAIL bne_new_datay: got target=%h taken=%b required 00000310/1",
                               jmp_if.jump_target, jmp_if.jump_taken);
        end
        ack_and_free();
    endtask

    task automatic test_jalr();
        int n;
        present(JALR, 32'h400, 32'h4, 32'h1003, 32'h0, 4'd0, 4'd5);
        tick(); wait_valid(n);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL jalr_no_tagy_stall: got %0d cycles required 2", n);
        end
        checks++;
        if (jmp_if.jump_target !== 32'h1006 || jmp_if.jump_taken !== 1'b1) begin
            errors++; $display("FAIL jalr_result: got target=%h taken=%b required 00001006/1",
                               jmp_if.jump_target, jmp_if.jump_taken);
        end
        ack_and_free();
    endtask

    task automatic test_back_to_back();
        int n;
        present(BGE, 32'h500, 32'h8, 32'd3, 32'd3, 4'd0, 4'd0);
        tick(); wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (jmp_if.jump_valid !== 1'b1 || jmp_if.jump_target !== 32'h508 ||
                jmp_if.jump_taken !== 1'b1 || busy_branch !== 1'b1) begin
                errors++; $display("FAIL req_hold%0d: got valid=%b target=%h taken=%b busy=%b required 1/00000508/1/1",
                                   i, jmp_if.jump_valid, jmp_if.jump_target, jmp_if.jump_taken, busy_branch);
            end
        end
        rdy = 1'b0;
        jmp_if.jump_ack = 1'b1;   // must be ignored while frozen
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (jmp_if.jump_valid !== 1'b1 || jmp_if.jump_target !== 32'h508 || busy_branch !== 1'b1) begin
                errors++; $display("FAIL rdy_freeze%0d: got valid=%b target=%h busy=%b required 1/00000508/1",
                                   i, jmp_if.jump_valid, jmp_if.jump_target, busy_branch);
            end
        end
        rdy = 1'b1;
        tick();
        jmp_if.jump_ack = 1'b0;
        checks++;
        if (jmp_if.jump_valid !== 1'b0 || busy_branch !== 1'b0) begin
            errors++; $display("FAIL b2b_first_ack: got valid=%b busy=%b required 0/0",
                               jmp_if.jump_valid, busy_branch);
        end
        present(BEQ, 32'h600, 32'h100, 32'd1, 32'd2, 4'd0, 4'd0);
        tick();
        checks++;
        if (busy_branch !== 1'b1) begin
            errors++; $display("FAIL b2b_capture: got busy=%b required 1", busy_branch);
        end
        wait_valid(n);
        checks++;
        if (n != 2 || jmp_if.jump_target !== 32'h604 || jmp_if.jump_taken !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got n=%0d target=%h taken=%b required 2/00000604/0",
                               n, jmp_if.jump_target, jmp_if.jump_taken);
        end
        ack_and_free();
    endtask

    task automatic test_reset_midflight();
        int n;
        // Reset while stalled in WAIT
        present(BEQ, 32'h800, 32'h10, 32'd1, 32'd1, 4'd2, 4'd0);
        tick(); tick();
        rst = 1'b1; busy_in = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy_branch, jmp_if.jump_valid, jmp_if.jump_taken} !== 3'b000 || jmp_if.jump_target !== 32'h0) begin
            errors++; $display("FAIL rst_in_wait: got busy=%b valid=%b taken=%b target=%h required all 0",
                               busy_branch, jmp_if.jump_valid, jmp_if.jump_taken, jmp_if.jump_target);
        end
        // Reset with a request pending and ack asserted at the same edge
        present(BEQ, 32'h900, 32'h10, 32'd1, 32'd1, 4'd0, 4'd0);
        tick(); wait_valid(n);
        rst = 1'b1; busy_in = 1'b0; jmp_if.jump_ack = 1'b1;
        tick();
        rst = 1'b0; jmp_if.jump_ack = 1'b0;
        checks++;
        if ({busy_branch, jmp_if.jump_valid, jmp_if.jump_taken} !== 3'b000 || jmp_if.jump_target !== 32'h0) begin
            errors++; $display("FAIL rst_in_req: got busy=%b valid=%b taken=%b target=%h required all 0",
                               busy_branch, jmp_if.jump_valid, jmp_if.jump_taken, jmp_if.jump_target);
        end
        // From IDLE a fresh entry resolves with normal latency; pc+4 wraps to 0.
        present(BNE, 32'hFFFF_FFFC, 32'h40, 32'd9, 32'd9, 4'd0, 4'd0);
        tick(); wait_valid(n);
        checks++;
        if (n != 2 || jmp_if.jump_target !== 32'h0 || jmp_if.jump_taken !== 1'b0) begin
            errors++; $display("FAIL pc_wrap: got n=%0d target=%h taken=%b required 2/00000000/0",
                               n, jmp_if.jump_target, jmp_if.jump_taken);
        end
        ack_and_free();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_beq_taken();
        test_signed_unsigned();
        test_tag_stall();
        test_jalr();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
